// File: rtl/spi_host_seq_if.sv
// Bundle of command/response stream and SPI pins for spi_host_seq.
// master is the host sequencer's view; slave is the side that feeds commands and models devices.
interface spi_host_seq_if #(
  parameter int NDevices = 1
);
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic [2:0]          cmd_dev_i;
  logic [7:0]          cmd_data_i;
  logic                cmd_last_i;
  logic                rsp_valid_o;
  logic [7:0]          rsp_data_o;
  logic                busy_o;
  logic                sck_o;
  logic [NDevices-1:0] cs_o;
  logic                copi_o;
  logic                cipo_i;

  modport master (
    input  cmd_valid_i, cmd_dev_i, cmd_data_i, cmd_last_i, cipo_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, busy_o, sck_o, cs_o, copi_o
  );

  modport slave (
    output cmd_valid_i, cmd_dev_i, cmd_data_i, cmd_last_i, cipo_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, busy_o, sck_o, cs_o, copi_o
  );
endinterface

// File: rtl/spi_host_seq.sv
// Byte-oriented mode-0 SPI host: CS framing, SCK generation, bursts with CS held, CS gap.
// Optional SPI_HOST_SEQ_LOOPBACK_EN adds loopback_i, which samples copi_o instead of cipo_i.
module spi_host_seq #(
  parameter int NDevices = 1,
  parameter int ClkDiv   = 2,
  parameter int CsGap    = 2
) (
  input logic clk_i,
  input logic rst_i,
`ifdef SPI_HOST_SEQ_LOOPBACK_EN
  input logic loopback_i,
`endif
  spi_host_seq_if.master bus
);

  localparam int HalfW = $clog2(ClkDiv + 1);
  localparam int GapW  = $clog2(CsGap + 1);
  localparam logic [HalfW-1:0] HalfLoad = HalfW'(ClkDiv - 1);
  localparam logic [GapW-1:0]  GapLoad  = GapW'(CsGap - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, NEXT, GAP} stateT;

  stateT               r_state;
  stateT               w_stateNext;
  logic [HalfW-1:0]    r_halfCnt;
  logic [GapW-1:0]     r_gapCnt;
  logic [2:0]          r_bitCnt;
  logic [2:0]          r_dev;
  logic                r_last;
  logic [7:0]          r_txShift;
  logic [7:0]          r_rxShift;
  logic [7:0]          r_rspData;
  logic                r_rspValid;
  logic                w_accept;
  logic                w_byteDone;
  logic                w_ready;
  logic                w_halfDone;
  logic                w_gapDone;
  logic                w_sample;
  logic [NDevices-1:0] w_cs;

  assign w_halfDone = (r_halfCnt == '0);
  assign w_gapDone  = (r_gapCnt == '0);

`ifdef SPI_HOST_SEQ_LOOPBACK_EN
  assign w_sample = loopback_i ? r_txShift[7] : bus.cipo_i;
`else
  assign w_sample = bus.cipo_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_byteDone  = 1'b0;
    w_ready     = 1'b0;
    w_cs        = '1;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.cmd_valid_i) begin
          w_accept    = 1'b1;
          w_stateNext = SETUP;
        end
      end
      SETUP: if (w_halfDone) w_stateNext = HIGH;
      HIGH:  if (w_halfDone) w_stateNext = LOW;
      LOW: begin
        if (w_halfDone) begin
          if (r_bitCnt == 3'd0) begin
            w_byteDone  = 1'b1;
            w_stateNext = r_last ? GAP : NEXT;
          end else begin
            w_stateNext = HIGH;
          end
        end
      end
      NEXT: begin
        w_ready = 1'b1;
        if (bus.cmd_valid_i) begin
          w_accept    = 1'b1;
          w_stateNext = SETUP;
        end
      end
      GAP:     if (w_gapDone) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
    // An out-of-range device index matches no select line, so the byte is clocked with CS idle.
    if (r_state inside {SETUP, HIGH, LOW, NEXT}) begin
      for (int i = 0; i < NDevices; i++) begin
        if (r_dev == 3'(i)) w_cs[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_halfCnt  <= '0;
      r_gapCnt   <= '0;
      r_bitCnt   <= 3'd0;
      r_dev      <= 3'd0;
      r_last     <= 1'b0;
      r_txShift  <= 8'h00;
      r_rxShift  <= 8'h00;
      r_rspData  <= 8'h00;
      r_rspValid <= 1'b0;
    end else begin
      r_rspValid <= w_byteDone;
      if (w_byteDone) r_rspData <= r_rxShift;

      if (w_stateNext != r_state) r_halfCnt <= HalfLoad;
      else if (!w_halfDone)       r_halfCnt <= r_halfCnt - HalfW'(1);

      if (w_stateNext == GAP && r_state != GAP)    r_gapCnt <= GapLoad;
      else if (r_state == GAP && !w_gapDone)       r_gapCnt <= r_gapCnt - GapW'(1);

      if (w_accept) begin
        r_txShift <= bus.cmd_data_i;
        r_last    <= bus.cmd_last_i;
        r_bitCnt  <= 3'd7;
        if (r_state == IDLE) r_dev <= bus.cmd_dev_i;
      end

      // Sample on the edge that raises SCK; launch the next bit on the edge that lowers it.
      if (r_state != HIGH && w_stateNext == HIGH) r_rxShift <= {r_rxShift[6:0], w_sample};
      if (r_state == HIGH && w_stateNext == LOW)  r_txShift <= {r_txShift[6:0], 1'b0};
      if (r_state == LOW && w_stateNext == HIGH)  r_bitCnt  <= r_bitCnt - 3'd1;
    end
  end

  assign bus.cmd_ready_o = w_ready & ~rst_i;
  assign bus.rsp_valid_o = r_rspValid;
  assign bus.rsp_data_o  = r_rspData;
  assign bus.busy_o      = (r_state != IDLE);
  assign bus.sck_o       = (r_state == HIGH);
  assign bus.cs_o        = w_cs;
  assign bus.copi_o      = r_txShift[7];

endmodule

// File: tb/tb_spi_host_seq.sv
// Directed bench for spi_host_seq with a mode-0 device model that shifts devByte out MSB first.
module tb_spi_host_seq;
  localparam int NDevices = 2;
  localparam int ClkDiv   = 2;
  localparam int CsGap    = 2;
  localparam int RspLat   = 17 * ClkDiv + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int nVec = 0;
  int nErr = 0;
  int riseTotal = 0;
  int byteBase = 0;
  logic [7:0] devByte = 8'h00;
`ifdef SPI_HOST_SEQ_LOOPBACK_EN
  logic loopback = 1'b0;
`endif

  spi_host_seq_if #(.NDevices(NDevices)) bus ();

  spi_host_seq #(
    .NDevices(NDevices),
    .ClkDiv(ClkDiv),
    .CsGap(CsGap)
  ) dut (
    .clk_i(clock),
    .rst_i(reset),
`ifdef SPI_HOST_SEQ_LOOPBACK_EN
    .loopback_i(loopback),
`endif
    .bus(bus)
  );

  always #5 clock = ~clock;

  always @(posedge bus.sck_o) riseTotal = riseTotal + 1;

  assign bus.cipo_i = devByte[3'(7 - ((riseTotal - byteBase) & 7))];

  task automatic doAccept(input logic [2:0] dev, input logic [7:0] data, input logic last, output bit ok);
    int n;
    n = 0;
    @(negedge clock);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_dev_i   = dev;
    bus.cmd_data_i  = data;
    bus.cmd_last_i  = last;
    while (bus.cmd_ready_o !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    ok = (bus.cmd_ready_o === 1'b1);
    @(posedge clock);
    #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    nVec++; if (bus.cmd_ready_o !== 1'b0) begin nErr++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.cmd_ready_o); end
    nVec++; if (bus.cs_o !== 2'b11) begin nErr++; $display("[TB] FAIL reset_cs: got %b expected 11", bus.cs_o); end
    nVec++; if (bus.sck_o !== 1'b0) begin nErr++; $display("[TB] FAIL reset_sck: got %b expected 0", bus.sck_o); end
    nVec++; if (bus.copi_o !== 1'b0) begin nErr++; $display("[TB] FAIL reset_copi: got %b expected 0", bus.copi_o); end
    nVec++; if (bus.rsp_data_o !== 8'h00) begin nErr++; $display("[TB] FAIL reset_rsp_data: got %h expected 00", bus.rsp_data_o); end
    nVec++; if (bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin nErr++; $display("[TB] FAIL reset_valid_busy: got %b%b expected 00", bus.rsp_valid_o, bus.busy_o); end
    reset = 1'b0;
    @(negedge clock);
    nVec++; if (bus.cmd_ready_o !== 1'b1) begin nErr++; $display("[TB] FAIL release_ready: got %b expected 1", bus.cmd_ready_o); end
  endtask

  task automatic test_single;
    bit ok;
    int firstRise, rises, pulses, rspLabel;
    logic prevSck;
    logic [7:0] copiBits, rspAt;
    logic [1:0] csAt1, csAt36, csAt37;
    logic copiAt1;
    firstRise = -1; rises = 0; pulses = 0; rspLabel = -1; prevSck = 1'b0;
    copiBits = 8'h00; rspAt = 8'h00; csAt1 = 2'b00; csAt36 = 2'b00; csAt37 = 2'b00; copiAt1 = 1'b0;
    devByte = 8'h3C;
    byteBase = riseTotal;
    doAccept(3'd0, 8'hA5, 1'b1, ok);
    nVec++; if (!ok) begin nErr++; $display("[TB] FAIL single_accept: got timeout expected accept"); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1) begin csAt1 = bus.cs_o; copiAt1 = bus.copi_o; end
      if (k == 36) csAt36 = bus.cs_o;
      if (k == 37) csAt37 = bus.cs_o;
      if (bus.sck_o === 1'b1 && prevSck === 1'b0) begin
        if (firstRise < 0) firstRise = k;
        copiBits = {copiBits[6:0], bus.copi_o};
        rises++;
      end
      prevSck = bus.sck_o;
      if (bus.rsp_valid_o === 1'b1) begin pulses++; rspLabel = k; rspAt = bus.rsp_data_o; end
    end
    nVec++; if (csAt1 !== 2'b10) begin nErr++; $display("[TB] FAIL single_cs_low: got %b expected 10", csAt1); end
    nVec++; if (copiAt1 !== 1'b1) begin nErr++; $display("[TB] FAIL single_copi_bit7: got %b expected 1", copiAt1); end
    nVec++; if (firstRise != 1 + ClkDiv) begin nErr++; $display("[TB] FAIL single_first_rise: got %0d expected %0d", firstRise, 1 + ClkDiv); end
    nVec++; if (rises != 8) begin nErr++; $display("[TB] FAIL single_rises: got %0d expected 8", rises); end
    nVec++; if (copiBits !== 8'hA5) begin nErr++; $display("[TB] FAIL single_copi_bits: got %h expected a5", copiBits); end
    nVec++; if (pulses != 1) begin nErr++; $display("[TB] FAIL single_pulses: got %0d expected 1", pulses); end
    nVec++; if (rspLabel != RspLat) begin nErr++; $display("[TB] FAIL single_rsp_time: got %0d expected %0d", rspLabel, RspLat); end
    nVec++; if (rspAt !== 8'h3C) begin nErr++; $display("[TB] FAIL single_rsp_data: got %h expected 3c", rspAt); end
    nVec++; if (csAt36[0] !== 1'b1 || csAt37[0] !== 1'b1) begin nErr++; $display("[TB] FAIL single_cs_release: got %b,%b expected x1,x1", csAt36, csAt37); end
    nVec++; if (bus.rsp_data_o !== 8'h3C) begin nErr++; $display("[TB] FAIL single_rsp_hold: got %h expected 3c", bus.rsp_data_o); end
  endtask

  task automatic test_burst;
    logic [7:0] txBytes [3];
    logic [7:0] rxBytes [3];
    bit ok;
    int idx, lat, n, csBreaks, cs0Lows, readyBad;
    txBytes = '{8'h11, 8'h22, 8'h33};
    rxBytes = '{8'hC1, 8'hC2, 8'hC3};
    idx = 0; lat = 0; n = 0; csBreaks = 0; cs0Lows = 0; readyBad = 0;
    devByte = rxBytes[0];
    byteBase = riseTotal;
    doAccept(3'd1, txBytes[0], 1'b0, ok);
    nVec++; if (!ok) begin nErr++; $display("[TB] FAIL burst_accept: got timeout expected accept"); end
    while (idx < 3 && n < 300) begin
      @(negedge clock);
      n++;
      lat++;
      if (bus.cs_o[0] !== 1'b1) cs0Lows++;
      if (bus.rsp_valid_o === 1'b1) begin
        nVec++; if (bus.rsp_data_o !== rxBytes[idx]) begin nErr++; $display("[TB] FAIL burst_rsp_data%0d: got %h expected %h", idx, bus.rsp_data_o, rxBytes[idx]); end
        nVec++; if (lat != RspLat) begin nErr++; $display("[TB] FAIL burst_latency%0d: got %0d expected %0d", idx, lat, RspLat); end
        if (idx < 2) begin
          nVec++; if (bus.cs_o[1] !== 1'b0) begin nErr++; $display("[TB] FAIL burst_cs_next%0d: got %b expected 0", idx, bus.cs_o[1]); end
          nVec++; if (bus.cmd_ready_o !== 1'b1) begin nErr++; $display("[TB] FAIL burst_ready_next%0d: got %b expected 1", idx, bus.cmd_ready_o); end
          devByte = rxBytes[idx+1];
          bus.cmd_valid_i = 1'b1;
          bus.cmd_dev_i   = 3'd0;
          bus.cmd_data_i  = txBytes[idx+1];
          bus.cmd_last_i  = (idx == 1);
          @(posedge clock);
          #1;
          bus.cmd_valid_i = 1'b0;
          lat = 0;
        end else begin
          nVec++; if (bus.cmd_ready_o !== 1'b0 || bus.cs_o !== 2'b11) begin nErr++; $display("[TB] FAIL burst_end_gap: got ready=%b cs=%b expected ready=0 cs=11", bus.cmd_ready_o, bus.cs_o); end
        end
        idx++;
      end else begin
        if (bus.cs_o[1] !== 1'b0) csBreaks++;
        if (bus.cmd_ready_o !== 1'b0) readyBad++;
      end
    end
    nVec++; if (idx != 3) begin nErr++; $display("[TB] FAIL burst_responses: got %0d expected 3", idx); end
    nVec++; if (csBreaks != 0) begin nErr++; $display("[TB] FAIL burst_cs1_held: got %0d breaks expected 0", csBreaks); end
    nVec++; if (cs0Lows != 0) begin nErr++; $display("[TB] FAIL burst_cs0_idle: got %0d lows expected 0", cs0Lows); end
    nVec++; if (readyBad != 0) begin nErr++; $display("[TB] FAIL burst_ready_busy: got %0d cycles expected 0", readyBad); end
  endtask

  task automatic test_gap;
    bit ok;
    int rspLabel, readyLabel, csHigh, lat, n;
    logic gotRsp;
    rspLabel = -1; readyLabel = -1; csHigh = 0; lat = 0; n = 0; gotRsp = 1'b0;
    devByte = 8'h7E;
    byteBase = riseTotal;
    doAccept(3'd0, 8'h81, 1'b1, ok);
    nVec++; if (!ok) begin nErr++; $display("[TB] FAIL gap_accept1: got timeout expected accept"); end
    bus.cmd_valid_i = 1'b1;
    bus.cmd_dev_i   = 3'd0;
    bus.cmd_data_i  = 8'h42;
    bus.cmd_last_i  = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      if (bus.rsp_valid_o === 1'b1 && rspLabel < 0) begin
        rspLabel = k;
        nVec++; if (bus.rsp_data_o !== 8'h7E) begin nErr++; $display("[TB] FAIL gap_rsp1: got %h expected 7e", bus.rsp_data_o); end
      end
      if (rspLabel >= 0) begin
        if (bus.cs_o[0] === 1'b1) csHigh++;
        if (bus.cmd_ready_o === 1'b1) begin
          readyLabel = k;
          devByte = 8'hB4;
          byteBase = riseTotal;
          @(posedge clock);
          #1;
          break;
        end
      end
    end
    bus.cmd_valid_i = 1'b0;
    nVec++; if (readyLabel < 0) begin nErr++; $display("[TB] FAIL gap_second_accept: got timeout expected accept"); end
    nVec++; if (csHigh < CsGap) begin nErr++; $display("[TB] FAIL gap_cs_high: got %0d cycles expected >= %0d", csHigh, CsGap); end
    nVec++; if (readyLabel + 1 - rspLabel < CsGap + 1) begin nErr++; $display("[TB] FAIL gap_accept_spacing: got %0d expected >= %0d", readyLabel + 1 - rspLabel, CsGap + 1); end
    while (!gotRsp && n < 60) begin
      @(negedge clock);
      n++;
      lat++;
      if (bus.rsp_valid_o === 1'b1) gotRsp = 1'b1;
    end
    nVec++; if (!gotRsp || lat != RspLat) begin nErr++; $display("[TB] FAIL gap_rsp2_time: got %0d expected %0d", lat, RspLat); end
    nVec++; if (bus.rsp_data_o !== 8'hB4) begin nErr++; $display("[TB] FAIL gap_rsp2_data: got %h expected b4", bus.rsp_data_o); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n, spurious, lat;
    logic gotRsp;
    n = 0; spurious = 0; lat = 0; gotRsp = 1'b0;
    devByte = 8'hE7;
    byteBase = riseTotal;
    doAccept(3'd1, 8'hF0, 1'b1, ok);
    nVec++; if (!ok) begin nErr++; $display("[TB] FAIL rstmid_accept: got timeout expected accept"); end
    while ((riseTotal - byteBase) < 4 && n < 100) begin
      @(negedge clock);
      n++;
    end
    nVec++; if ((riseTotal - byteBase) != 4) begin nErr++; $display("[TB] FAIL rstmid_rises: got %0d expected 4", riseTotal - byteBase); end
    reset = 1'b1;
    @(negedge clock);
    nVec++; if (bus.cs_o !== 2'b11 || bus.sck_o !== 1'b0) begin nErr++; $display("[TB] FAIL rstmid_pins: got cs=%b sck=%b expected cs=11 sck=0", bus.cs_o, bus.sck_o); end
    nVec++; if (bus.busy_o !== 1'b0 || bus.copi_o !== 1'b0 || bus.rsp_data_o !== 8'h00) begin nErr++; $display("[TB] FAIL rstmid_outputs: got busy=%b copi=%b rsp=%h expected 0 0 00", bus.busy_o, bus.copi_o, bus.rsp_data_o); end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.rsp_valid_o !== 1'b0) spurious++;
    end
    nVec++; if (spurious != 0) begin nErr++; $display("[TB] FAIL rstmid_no_rsp: got %0d pulses expected 0", spurious); end
    devByte = 8'h69;
    byteBase = riseTotal;
    doAccept(3'd0, 8'h0F, 1'b1, ok);
    nVec++; if (!ok) begin nErr++; $display("[TB] FAIL rstmid_accept2: got timeout expected accept"); end
    n = 0;
    while (!gotRsp && n < 60) begin
      @(negedge clock);
      n++;
      lat++;
      if (bus.rsp_valid_o === 1'b1) gotRsp = 1'b1;
    end
    nVec++; if (!gotRsp || lat != RspLat || bus.rsp_data_o !== 8'h69) begin nErr++; $display("[TB] FAIL rstmid_recover: got lat=%0d data=%h expected lat=%0d data=69", lat, bus.rsp_data_o, RspLat); end
  endtask

  task automatic test_bad_dev;
    bit ok;
    int n, lat, csLow;
    logic gotRsp;
    n = 0; lat = 0; csLow = 0; gotRsp = 1'b0;
    devByte = 8'h96;
    byteBase = riseTotal;
    doAccept(3'd5, 8'hC3, 1'b1, ok);
    nVec++; if (!ok) begin nErr++; $display("[TB] FAIL baddev_accept: got timeout expected accept"); end
    while (!gotRsp && n < 60) begin
      @(negedge clock);
      n++;
      lat++;
      if (bus.cs_o !== 2'b11) csLow++;
      if (bus.rsp_valid_o === 1'b1) gotRsp = 1'b1;
    end
    nVec++; if (csLow != 0) begin nErr++; $display("[TB] FAIL baddev_cs: got %0d low cycles expected 0", csLow); end
    nVec++; if (!gotRsp || lat != RspLat || bus.rsp_data_o !== 8'h96) begin nErr++; $display("[TB] FAIL baddev_rsp: got lat=%0d data=%h expected lat=%0d data=96", lat, bus.rsp_data_o, RspLat); end
  endtask

`ifdef SPI_HOST_SEQ_LOOPBACK_EN
  task automatic test_loopback;
    bit ok;
    int n;
    logic gotRsp;
    n = 0; gotRsp = 1'b0;
    loopback = 1'b1;
    devByte = 8'hFF;
    byteBase = riseTotal;
    doAccept(3'd0, 8'h5A, 1'b1, ok);
    nVec++; if (!ok) begin nErr++; $display("[TB] FAIL loopback_accept: got timeout expected accept"); end
    while (!gotRsp && n < 60) begin
      @(negedge clock);
      n++;
      if (bus.rsp_valid_o === 1'b1) gotRsp = 1'b1;
    end
    nVec++; if (!gotRsp || bus.rsp_data_o !== 8'h5A) begin nErr++; $display("[TB] FAIL loopback_rsp: got %h expected 5a", bus.rsp_data_o); end
    loopback = 1'b0;
  endtask
`endif

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_dev_i   = 3'd0;
    bus.cmd_data_i  = 8'h00;
    bus.cmd_last_i  = 1'b0;
    $display("[TB] spi_host_seq bench start");
    test_reset;
    test_single;
    repeat (4) @(negedge clock);
    test_burst;
    repeat (4) @(negedge clock);
    test_gap;
    repeat (4) @(negedge clock);
    test_reset_mid;
    repeat (4) @(negedge clock);
    test_bad_dev;
`ifdef SPI_HOST_SEQ_LOOPBACK_EN
    repeat (4) @(negedge clock);
    test_loopback;
`endif
    repeat (4) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
